daq_depacketizer: RTL

- Downstream stage of the DAQ packetizer. Consumes its 8-bit AXI-stream frame, checks the sync word, and extracts frame metadata.
- Reassembles the payload into 32-bit sample words on a 32-bit AXI-stream, tagged with channel ID.
- Reports per-frame status and saturating error statistics to the host/capture FIFO side.

---
 rtl/daq_pkt_pkg.sv | 33 +++
 rtl/daq_depacketizer_if.sv | 25 ++
 rtl/daq_sat_cnt16.sv | 14 +
 rtl/daq_depacketizer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkt_pkg.sv
// Shared DAQ frame definitions: sync word, field sizes, status bit positions
// and the depacketizer state set.
package daq_pkt_pkg;

   localparam logic [31:0] DAQ_SYNC_WORD = 32'h30415144;

   localparam int unsigned HDR_BYTES  = 4;
   localparam int unsigned TS_BYTES   = 4;
   localparam int unsigned INFO_BYTES = 4;

   localparam int unsigned ST_TRUNC   = 0;
   localparam int unsigned ST_OVERRUN = 1;
   localparam int unsigned ST_BADTR   = 2;
   localparam int unsigned ST_INFO    = 3;

   typedef enum logic [3:0] {
      S_HUNT,
      S_HDR,
      S_TS,
      S_CHN,
      S_CNT,
      S_PAYLOAD,
      S_INFO,
      S_TRAILER,
      S_DROP
   } dp_state_e;

   // Sync bytes go out LSB first.
   function automatic logic [7:0] sync_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/daq_depacketizer_if.sv
// Byte-stream input and sample-word output handshakes of the depacketizer.
interface daq_depacketizer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned USER_W = 8
);
   logic [7:0]        s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic              s_tlast;
   logic [DATA_W-1:0] m_tdata;
   logic [USER_W-1:0] m_tuser;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tuser, m_tvalid, m_tlast
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tuser, m_tvalid, m_tlast
   );
endinterface

// File: rtl/daq_sat_cnt16.sv
// Enable-driven 16-bit event counter that sticks at all-ones.
module daq_sat_cnt16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] cnt
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (en && (cnt != '1))
         cnt <= cnt + 16'd1;
   end
endmodule

// File: rtl/daq_depacketizer.sv
// DAQ frame depacketizer: sync hunt, metadata capture, 8->32 bit payload
// reassembly with a single output register, per-frame status and statistics.
module daq_depacketizer
   import daq_pkt_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned USER_W    = 8,
   parameter logic [31:0] SYNC_WORD = DAQ_SYNC_WORD
) (
   input  logic         clk,
   input  logic         rst,
   daq_depacketizer_if.slave bus,
   output logic         frame_done,
   output logic [3:0]   frame_status,
   output logic [31:0]  meta_ts,
   output logic [7:0]   meta_chn,
   output logic [7:0]   meta_cnt,
   output logic [31:0]  meta_info,
   output logic [15:0]  cnt_ok,
   output logic [15:0]  cnt_bad,
   output logic [15:0]  cnt_sync_err
);
   localparam logic [1:0] HDR_LAST  = 2'(HDR_BYTES - 1);
   localparam logic [1:0] TS_LAST   = 2'(TS_BYTES - 1);
   localparam logic [1:0] INFO_LAST = 2'(INFO_BYTES - 1);

   dp_state_e         state, state_n;
   logic [1:0]        idx, bcnt;
   logic [23:0]       wacc;
   logic [7:0]        wcnt, chn_q, cnt_q, b;
   logic [31:0]       ts_q, info_q;
   logic              ovr_q, bad_q;
   logic              acc, fr_end, sync_err, emit, word_last, start;
   logic              set_trunc, set_ovr, set_bad, ok_en, bad_en;
   logic [3:0]        status_n;
   logic [DATA_W-1:0] cur_word;

   assign b            = bus.s_tdata;
   assign bus.s_tready = (state != S_PAYLOAD) || !bus.m_tvalid || bus.m_tready;
   assign acc          = bus.s_tvalid && bus.s_tready;
   assign word_last    = (wcnt == (cnt_q - 8'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_HUNT;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      fr_end    = 1'b0;
      sync_err  = 1'b0;
      emit      = 1'b0;
      start     = 1'b0;
      set_trunc = 1'b0;
      set_ovr   = 1'b0;
      set_bad   = 1'b0;
      if (acc) begin
         case (state)
            S_HUNT:
               if (!bus.s_tlast && (b == sync_byte(SYNC_WORD, 2'd0))) state_n = S_HDR;
            S_HDR:
               if (b == sync_byte(SYNC_WORD, idx)) begin
                  if (bus.s_tlast) state_n = S_HUNT;
                  else if (idx == HDR_LAST) begin
                     state_n = S_TS;
                     start   = 1'b1;
                  end
               end else begin
                  sync_err = 1'b1;
                  state_n  = (!bus.s_tlast && (b == sync_byte(SYNC_WORD, 2'd0))) ? S_HDR : S_HUNT;
               end
            S_TS:
               if (bus.s_tlast) begin
                  set_trunc = 1'b1; fr_end = 1'b1; state_n = S_HUNT;
               end else if (bcnt == TS_LAST) state_n = S_CHN;
            S_CHN:
               if (bus.s_tlast) begin
                  set_trunc = 1'b1; fr_end = 1'b1; state_n = S_HUNT;
               end else state_n = S_CNT;
            S_CNT:
               if (bus.s_tlast) begin
                  set_trunc = 1'b1; fr_end = 1'b1; state_n = S_HUNT;
               end else state_n = (b == 8'd0) ? S_INFO : S_PAYLOAD;
            S_PAYLOAD:
               if (bus.s_tlast) begin
                  emit = 1'b1; set_trunc = 1'b1; fr_end = 1'b1; state_n = S_HUNT;
               end else if (bcnt == 2'd3) begin
                  emit = 1'b1;
                  if (word_last) state_n = S_INFO;
               end
            S_INFO:
               if (bus.s_tlast) begin
                  set_trunc = 1'b1; fr_end = 1'b1; state_n = S_HUNT;
               end else if (bcnt == INFO_LAST) state_n = S_TRAILER;
            S_TRAILER: begin
               set_bad = (b != 8'd0);
               if (bus.s_tlast) begin
                  fr_end = 1'b1; state_n = S_HUNT;
               end else begin
                  set_ovr = 1'b1; state_n = S_DROP;
               end
            end
            S_DROP:
               if (bus.s_tlast) begin
                  fr_end = 1'b1; state_n = S_HUNT;
               end
            default: state_n = S_HUNT;
         endcase
      end
   end

   // Truncated words keep unreceived upper bytes at zero.
   always_comb begin
      case (bcnt)
         2'd0:    cur_word = {24'h0, b};
         2'd1:    cur_word = {16'h0, b, wacc[7:0]};
         2'd2:    cur_word = {8'h0, b, wacc[15:0]};
         default: cur_word = {b, wacc};
      endcase
   end

   always_comb begin
      status_n             = '0;
      status_n[ST_TRUNC]   = set_trunc;
      status_n[ST_OVERRUN] = ovr_q | set_ovr;
      status_n[ST_BADTR]   = bad_q | set_bad;
      status_n[ST_INFO]    = (info_q != '0);
      ok_en                = fr_end && (status_n[2:0] == 3'd0);
      bad_en               = fr_end && (status_n[2:0] != 3'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx          <= '0;
         bcnt         <= '0;
         wacc         <= '0;
         wcnt         <= '0;
         chn_q        <= '0;
         cnt_q        <= '0;
         ts_q         <= '0;
         info_q       <= '0;
         ovr_q        <= 1'b0;
         bad_q        <= 1'b0;
         bus.m_tdata  <= '0;
         bus.m_tuser  <= '0;
         bus.m_tvalid <= 1'b0;
         bus.m_tlast  <= 1'b0;
         frame_done   <= 1'b0;
         frame_status <= '0;
         meta_ts      <= '0;
         meta_chn     <= '0;
         meta_cnt     <= '0;
         meta_info    <= '0;
      end else begin
         frame_done <= fr_end;
         if (bus.m_tvalid && bus.m_tready) bus.m_tvalid <= 1'b0;
         if (emit) begin
            bus.m_tdata  <= cur_word;
            bus.m_tuser  <= {bus.s_tlast, chn_q[USER_W-2:0]};
            bus.m_tlast  <= word_last || bus.s_tlast;
            bus.m_tvalid <= 1'b1;
         end
         if (acc) begin
            case (state)
               S_HUNT: idx <= 2'd1;
               S_HDR: begin
                  idx <= (b == sync_byte(SYNC_WORD, idx)) ? idx + 2'd1 : 2'd1;
                  if (start) begin
                     bcnt   <= '0;
                     ts_q   <= '0;
                     chn_q  <= '0;
                     cnt_q  <= '0;
                     info_q <= '0;
                  end
               end
               S_TS: begin
                  ts_q <= {b, ts_q[31:8]};
                  bcnt <= bcnt + 2'd1;
               end
               S_CHN: chn_q <= b;
               S_CNT: begin
                  cnt_q <= b;
                  wcnt  <= '0;
                  bcnt  <= '0;
               end
               S_PAYLOAD:
                  if (emit) begin
                     wcnt <= wcnt + 8'd1;
                     bcnt <= '0;
                  end else begin
                     bcnt <= bcnt + 2'd1;
                     case (bcnt)
                        2'd0:    wacc[7:0]   <= b;
                        2'd1:    wacc[15:8]  <= b;
                        default: wacc[23:16] <= b;
                     endcase
                  end
               S_INFO: begin
                  info_q <= {b, info_q[31:8]};
                  bcnt   <= bcnt + 2'd1;
               end
               default: ;
            endcase
         end
         if (start) begin
            ovr_q <= 1'b0;
            bad_q <= 1'b0;
         end else begin
            ovr_q <= ovr_q | set_ovr;
            bad_q <= bad_q | set_bad;
         end
         if (fr_end) begin
            frame_status <= status_n;
            meta_ts      <= ts_q;
            meta_chn     <= chn_q;
            meta_cnt     <= cnt_q;
            meta_info    <= info_q;
         end
      end
   end

   daq_sat_cnt16 u_cnt_ok   (.clk(clk), .rst(rst), .en(ok_en),    .cnt(cnt_ok));
   daq_sat_cnt16 u_cnt_bad  (.clk(clk), .rst(rst), .en(bad_en),   .cnt(cnt_bad));
   daq_sat_cnt16 u_cnt_sync (.clk(clk), .rst(rst), .en(sync_err), .cnt(cnt_sync_err));

endmodule
